instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Parametrised prefetch queue with RVC realignment, between the fetch unit and decode.
//  Accepts word-aligned 32-bit fetch words and emits one realigned instruction per handshake.
//  Output carries the PC, the compressed flag and the error flag.
//  Next generation of the 3-entry fetch FIFO: configurable depth, valid/ready on both sides,
//  internal PC tracking, redirect flush and fetch-error propagation.
// PARAMETERS
//  DEPTH     4               word entries, >=2; need not be a power of 2
//  XLEN      32              address width
//  RESET_PC  32'h1000_0000   PC of first instruction after reset
//  ENABLE_C  1               1: RVC support; 0: every instruction is 32-bit, hw_off never set
// PORTS
//  clk_i           in   1     clock
//  rst_ni          in   1     asynchronous reset, active-low
//  flush_i         in   1     drop all contents, restart at redirect_pc_i
//  redirect_pc_i   in   XLEN  new PC, sampled when flush_i=1
//  in_valid_i      in   1     fetch word valid
//  in_ready_o      out  1     space available
//  in_data_i       in   32    fetch word (word-aligned)
//  in_err_i        in   1     bus/access error on this word
//  out_valid_o     out  1     instruction available
//  out_ready_i     in   1     decode accepts
//  out_pc_o        out  XLEN  instruction PC
//  out_instr_o     out  32    instruction; compressed form zero-extended in [15:0]
//  out_compressed_o out 1     out_instr_o[1:0] != 2'b11 (0 when ENABLE_C=0)
//  out_err_o       out  1     fetch error for any word this instruction uses
// BEHAVIOUR
//  Reset:
//  - clk_i and rst_ni are as listed in PORTS.
//  - Reset values: count=0, rd/wr ptr=0, hw_off=0, pc_q=RESET_PC.
//  - Output reset values: in_ready_o=1, out_valid_o=0, out_pc_o=RESET_PC, out_instr_o=0,
//    out_compressed_o=0, out_err_o=0.
//  Storage and push:
//  - Circular buffer of DEPTH {data,err} entries; pointers wrap at DEPTH-1 -> 0.
//  - count is $clog2(DEPTH+1) bits wide.
//  - in_ready_o = (count < DEPTH). It depends on registered state only; no comb path from out_ready_i.
//  - Push when in_valid_i && in_ready_o: write at wr_ptr, wr_ptr+1, count+1 (+0 if a pop consumes a word).
//  Output formation:
//  - w0 = entry at rd_ptr; w1 = entry at rd_ptr+1 (wrapped).
//  - hw_off=0: instr = w0. Valid if count>=1.
//  - hw_off=1, compressed (w0[17:16]!=11): instr = {16'b0, w0[31:16]}. Valid if count>=1.
//  - hw_off=1, 32-bit: instr = {w1[15:0], w0[31:16]}. Valid if count>=2.
//    Exception: if w0.err, valid with count>=1, err=1 and instr=0.
//  - out_err_o = w0.err | (spanning & w1.err).
//  - An instruction is presented the cycle after its words are written (no bypass): latency 1 cycle.
//  Pop (out_valid_o && out_ready_i):
//  - aligned 32b:   pc+4, consume 1 word, hw_off stays 0.
//  - aligned C:     pc+2, consume 0 words, hw_off->1.
//  - unaligned C:   pc+2, consume 1 word, hw_off->0.
//  - unaligned 32b: pc+4, consume 1 word (w1 stays, its upper half is next), hw_off stays 1.
//  - PC arithmetic is modulo 2^XLEN.
//  - Outputs hold stable while out_valid_o && !out_ready_i.
//  Simultaneous and boundary cases:
//  - Push and pop in the same cycle are both honoured; count adjusts by the net amount.
//  - Full: push blocked; pops are unaffected.
//  - Empty: out_valid_o=0; out_instr_o, out_compressed_o and out_err_o driven 0.
//  Flush (synchronous, highest priority):
//  - Next cycle: count=0, ptrs=0, pc_q=redirect_pc_i, hw_off=redirect_pc_i[1] & ENABLE_C.
//  - A push or pop in the flush cycle is discarded; out_valid_o is forced 0 during flush_i.
//  - The fetch unit guarantees in_valid_i words after a flush belong to the redirected stream,
//    starting at redirect_pc_i & ~3.
//  - Flush while rst_ni is low has no effect. Reset mid-operation clears everything immediately.
// STRUCTURE
//  - fetch_pkg: typedef fetch_entry_t {logic [31:0] data; logic err;}, and the constant
//    C_OPCODE_32 = 2'b11. The is_compressed() function lives in fetch_pkg; it is pure and
//    applied to a 16-bit parcel.
//  - Sub-module instr_realigner: combinational; inputs w0, w1, hw_off; outputs instr,
//    compressed, spanning and the needs-two-words flag.
//  - This module keeps the storage, pointers, count, pc_q and hw_off.
// TESTING
//  1 Reset, then push 0x00000013 (addi) -> next cycle out_valid=1, pc=0x1000_0000, instr=0x00000013, compressed=0.
//  2 Push 0x4505_4501 (two C.li) -> pops pc 0x..00 instr 0x4501, then pc 0x..02 instr 0x4505, then empty.
//  3 Push 0x0013_4501, then 0x1111_0000 -> C at pc+0; then 32-bit at pc+2 instr 0x00000013;
//    out_valid=0 until the second word arrives.
//  4 DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after 4th, 5th held; one pop frees a
//    slot the same cycle, 5th accepted; pointers wrap without loss.
//  5 flush_i with redirect 0x2000_0006 mid-stream -> next cycle empty; push 0xABCD_0001 ->
//    instr 0x0000ABCD? no: instr = upper half 0xABCD at pc 0x2000_0006 (compressed).
//  6 Word A err=1 spanned by unaligned 32-bit instr -> out_valid=1 with count=1, out_err=1,
//    instr=0; ENABLE_C=0 run: 0x4501 treated as 32-bit, pc+4.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and helpers for the instruction prefetch path.
//   fetch_entry_t : one stored fetch word plus its bus-error flag
//   C_OPCODE_32   : low two opcode bits that mark a full 32-bit instruction
//   is_compressed : returns 1 if a 16-bit parcel starts an RVC instruction
package fetch_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

  localparam logic [1:0] C_OPCODE_32 = 2'b11;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != C_OPCODE_32;
  endfunction

endpackage

// File: rtl/instr_realigner.sv
// instr_realigner
//   Combinational extraction of one instruction from the two oldest fetch
//   words, given the half-word offset of the current PC.
//   w0        in   32  word at the read pointer
//   w1_lo     in   16  lower half of the following word
//   hw_off    in    1  current PC sits in the upper half of w0
//   instr     out  32  realigned instruction (compressed form zero-extended)
//   compressed out  1  instruction is RVC
//   spanning  out   1  instruction crosses from w0 into w1
//   needs_two out   1  both words must be present to form the instruction
module instr_realigner
  import fetch_pkg::*;
#(
  parameter int unsigned ENABLE_C = 1
) (
  input  logic [31:0] w0,
  input  logic [15:0] w1_lo,
  input  logic        hw_off,
  output logic [31:0] instr,
  output logic        compressed,
  output logic        spanning,
  output logic        needs_two
);

  localparam logic EN_C = (ENABLE_C != 0);

  logic [15:0] upper;
  logic        c_lo;
  logic        c_hi;

  always_comb begin
    upper      = w0[31:16];
    c_lo       = EN_C && is_compressed(w0[15:0]);
    c_hi       = EN_C && is_compressed(upper);
    instr      = '0;
    compressed = 1'b0;
    spanning   = 1'b0;
    needs_two  = 1'b0;
    if (hw_off && EN_C) begin
      if (c_hi) begin
        instr      = {16'h0000, upper};
        compressed = 1'b1;
      end else begin
        instr     = {w1_lo, upper};
        spanning  = 1'b1;
        needs_two = 1'b1;
      end
    end else if (c_lo) begin
      instr      = {16'h0000, w0[15:0]};
      compressed = 1'b1;
    end else begin
      instr = w0;
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//   Prefetch queue between fetch and decode. Stores word-aligned fetch words
//   in a circular buffer and emits one realigned (RVC-aware) instruction per
//   output handshake, tracking the PC internally.
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i, redirect_pc_i   drop contents and restart at redirect_pc_i
//   in_valid_i/in_ready_o    fetch word handshake (in_data_i, in_err_i)
//   out_valid_o/out_ready_i  instruction handshake
//   out_pc_o, out_instr_o, out_compressed_o, out_err_o  instruction fields
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned            DEPTH    = 4,
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = 32'h1000_0000,
  parameter int unsigned            ENABLE_C = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_data_i,
  input  logic            in_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic            out_compressed_o,
  output logic            out_err_o
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic        EN_C = (ENABLE_C != 0);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_q;
  logic            hw_off_q;

  fetch_entry_t    w0;
  fetch_entry_t    w1;
  logic [31:0]     r_instr;
  logic            r_comp;
  logic            r_span;
  logic            r_two;

  logic            valid_raw;
  logic            push;
  logic            pop;
  logic            consume;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w0 = mem_q[rd_ptr_q];
  assign w1 = mem_q[ptr_inc(rd_ptr_q)];

  instr_realigner #(
    .ENABLE_C (ENABLE_C)
  ) u_realigner (
    .w0         (w0.data),
    .w1_lo      (w1.data[15:0]),
    .hw_off     (hw_off_q),
    .instr      (r_instr),
    .compressed (r_comp),
    .spanning   (r_span),
    .needs_two  (r_two)
  );

  // A spanning instruction whose first word already faulted is reported
  // without waiting for the second word.
  assign valid_raw = (count_q != '0) &&
                     (!r_two || (count_q >= CW'(2)) || w0.err);

  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = valid_raw && !flush_i;
  assign out_pc_o    = pc_q;

  always_comb begin
    out_instr_o      = '0;
    out_compressed_o = 1'b0;
    out_err_o        = 1'b0;
    if (out_valid_o) begin
      out_instr_o      = (r_span && w0.err) ? 32'h0 : r_instr;
      out_compressed_o = r_comp;
      out_err_o        = w0.err | (r_span & w1.err);
    end
  end

  assign push    = in_valid_i && in_ready_o && !flush_i;
  assign pop     = out_valid_o && out_ready_i;
  // Only an aligned compressed instruction leaves its word in place.
  assign consume = pop && (!r_comp || hw_off_q);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: in_data_i, err: in_err_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
      hw_off_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= redirect_pc_i;
      hw_off_q <= redirect_pc_i[1] & EN_C;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (consume) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (pop) begin
        pc_q <= pc_q + (r_comp ? XLEN'(2) : XLEN'(4));
        // Compressed toggles the half-word offset; 32-bit keeps it.
        if (r_comp) begin
          hw_off_q <= !hw_off_q;
        end
      end
      count_q <= count_q + CW'(push) - CW'(consume);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

  localparam logic [31:0] P = 32'h1000_0000;

  logic        clk;
  logic        rst_n;

  logic        fl, iv, ie, rdy;
  logic [31:0] rpc, id;
  logic        ov, ir, oc, oe;
  logic [31:0] opc, oi;

  logic        fl2, iv2, ie2, rdy2;
  logic [31:0] rpc2, id2;
  logic        ov2, ir2, oc2, oe2;
  logic [31:0] opc2, oi2;

  int n_pass = 0;
  int n_total = 0;

  instr_prefetch_buffer #(.DEPTH(4), .XLEN(32), .RESET_PC(P), .ENABLE_C(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl), .redirect_pc_i(rpc),
    .in_valid_i(iv), .in_ready_o(ir), .in_data_i(id), .in_err_i(ie),
    .out_valid_o(ov), .out_ready_i(rdy), .out_pc_o(opc), .out_instr_o(oi),
    .out_compressed_o(oc), .out_err_o(oe)
  );

  instr_prefetch_buffer #(.DEPTH(3), .XLEN(32), .RESET_PC(P), .ENABLE_C(0)) dut_noc (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl2), .redirect_pc_i(rpc2),
    .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(id2), .in_err_i(ie2),
    .out_valid_o(ov2), .out_ready_i(rdy2), .out_pc_o(opc2), .out_instr_o(oi2),
    .out_compressed_o(oc2), .out_err_o(oe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] rpc;
    logic        iv;
    logic [31:0] d;
    logic        e;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        ec;
    logic        ee;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic [31:0] r, input logic v, input logic [31:0] d,
                     input logic e, input logic rd, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic ec, input logic ee, input logic er);
    vec_t t;
    t = '{f, r, v, d, e, rd, ev, epc, ei, ec, ee, er};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic chk_main(input int idx, input logic ev, input logic [31:0] epc,
                          input logic [31:0] ei, input logic ec, input logic ee,
                          input logic er);
    chk("out_valid", idx, {31'b0, ov}, {31'b0, ev});
    chk("out_pc", idx, opc, epc);
    chk("out_instr", idx, oi, ei);
    chk("out_compressed", idx, {31'b0, oc}, {31'b0, ec});
    chk("out_err", idx, {31'b0, oe}, {31'b0, ee});
    chk("in_ready", idx, {31'b0, ir}, {31'b0, er});
  endtask

  initial begin
    // fl rpc iv data err rdy | valid pc instr comp err ready
    add(0, 0, 0, 0,            0, 0, 0, P,         0,            0, 0, 1); // 0 reset
    add(0, 0, 1, 32'h00000013, 0, 0, 0, P,         0,            0, 0, 1); // 1
    add(0, 0, 0, 0,            0, 1, 1, P,         32'h00000013, 0, 0, 1); // 2
    add(0, 0, 1, 32'h45054501, 0, 0, 0, P+4,       0,            0, 0, 1); // 3
    add(0, 0, 0, 0,            0, 1, 1, P+4,       32'h00004501, 1, 0, 1); // 4
    add(0, 0, 0, 0,            0, 1, 1, P+6,       32'h00004505, 1, 0, 1); // 5
    add(0, 0, 1, 32'h00134501, 0, 0, 0, P+8,       0,            0, 0, 1); // 6
    add(0, 0, 0, 0,            0, 1, 1, P+8,       32'h00004501, 1, 0, 1); // 7
    add(0, 0, 0, 0,            0, 1, 0, P+32'hA,   0,            0, 0, 1); // 8
    add(0, 0, 1, 32'h11110000, 0, 1, 0, P+32'hA,   0,            0, 0, 1); // 9
    add(0, 0, 0, 0,            0, 1, 1, P+32'hA,   32'h00000013, 0, 0, 1); // 10
    add(0, 0, 0, 0,            0, 1, 1, P+32'hE,   32'h00001111, 1, 0, 1); // 11
    add(0, 0, 1, 32'h00100093, 0, 0, 0, P+32'h10,  0,            0, 0, 1); // 12
    add(0, 0, 1, 32'h00200113, 0, 0, 1, P+32'h10,  32'h00100093, 0, 0, 1); // 13
    add(0, 0, 1, 32'h00300193, 0, 0, 1, P+32'h10,  32'h00100093, 0, 0, 1); // 14
    add(0, 0, 1, 32'h00400213, 0, 0, 1, P+32'h10,  32'h00100093, 0, 0, 1); // 15
    add(0, 0, 1, 32'h00500293, 0, 0, 1, P+32'h10,  32'h00100093, 0, 0, 0); // 16 full
    add(0, 0, 1, 32'h00500293, 0, 1, 1, P+32'h10,  32'h00100093, 0, 0, 0); // 17 pop
    add(0, 0, 1, 32'h00500293, 0, 0, 1, P+32'h14,  32'h00200113, 0, 0, 1); // 18 push
    add(0, 0, 0, 0,            0, 1, 1, P+32'h14,  32'h00200113, 0, 0, 0); // 19
    add(0, 0, 0, 0,            0, 1, 1, P+32'h18,  32'h00300193, 0, 0, 1); // 20
    add(0, 0, 0, 0,            0, 1, 1, P+32'h1C,  32'h00400213, 0, 0, 1); // 21
    add(0, 0, 0, 0,            0, 1, 1, P+32'h20,  32'h00500293, 0, 0, 1); // 22
    add(0, 0, 1, 32'h00000013, 0, 0, 0, P+32'h24,  0,            0, 0, 1); // 23
    add(0, 0, 1, 32'h45054501, 0, 1, 1, P+32'h24,  32'h00000013, 0, 0, 1); // 24 push+pop
    add(0, 0, 0, 0,            0, 1, 1, P+32'h28,  32'h00004501, 1, 0, 1); // 25
    add(1, 32'h20000006, 1, 32'hDEADBEEF, 0, 1, 0, P+32'h2A, 0,  0, 0, 1); // 26 flush
    add(0, 0, 1, 32'hABCD0001, 0, 0, 0, 32'h20000006, 0,         0, 0, 1); // 27
    add(0, 0, 0, 0,            0, 1, 1, 32'h20000006, 32'h0000ABCD, 1, 0, 1); // 28
    add(1, 32'h30000002, 0, 0, 0, 0, 0, 32'h20000008, 0,         0, 0, 1); // 29
    add(0, 0, 1, 32'h00130000, 1, 0, 0, 32'h30000002, 0,         0, 0, 1); // 30
    add(0, 0, 0, 0,            0, 0, 1, 32'h30000002, 0,         0, 1, 1); // 31 err count=1
    add(0, 0, 1, 32'h00000001, 0, 0, 1, 32'h30000002, 0,         0, 1, 1); // 32 hold
    add(0, 0, 0, 0,            0, 1, 1, 32'h30000002, 0,         0, 1, 1); // 33
    add(0, 0, 0, 0,            0, 1, 1, 32'h30000006, 0,         1, 0, 1); // 34
    add(1, 32'h40000002, 0, 0, 0, 0, 0, 32'h30000008, 0,         0, 0, 1); // 35
    add(0, 0, 1, 32'h00130000, 0, 0, 0, 32'h40000002, 0,         0, 0, 1); // 36
    add(0, 0, 1, 32'h00000001, 1, 0, 0, 32'h40000002, 0,         0, 0, 1); // 37
    add(0, 0, 0, 0,            0, 1, 1, 32'h40000002, 32'h00010013, 0, 1, 1); // 38 w1 err
    add(0, 0, 0, 0,            0, 1, 1, 32'h40000006, 0,         1, 1, 1); // 39
    add(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'h40000008, 0,         0, 0, 1); // 40
    add(0, 0, 1, 32'h00000013, 0, 0, 0, 32'hFFFFFFFC, 0,         0, 0, 1); // 41
    add(0, 0, 0, 0,            0, 1, 1, 32'hFFFFFFFC, 32'h00000013, 0, 0, 1); // 42
    add(0, 0, 0, 0,            0, 0, 0, 32'h00000000, 0,         0, 0, 1); // 43 wrap

    rst_n = 1'b0;
    fl = 0; rpc = 0; iv = 0; id = 0; ie = 0; rdy = 0;
    fl2 = 0; rpc2 = 0; iv2 = 0; id2 = 0; ie2 = 0; rdy2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      fl = vecs[i].fl; rpc = vecs[i].rpc; iv = vecs[i].iv;
      id = vecs[i].d; ie = vecs[i].e; rdy = vecs[i].rdy;
      #1;
      chk_main(i, vecs[i].ev, vecs[i].epc, vecs[i].ei, vecs[i].ec, vecs[i].ee, vecs[i].er);
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    fl = 0; iv = 1; id = 32'h00000013; ie = 0; rdy = 0;
    @(negedge clk);
    iv = 0;
    #1;
    chk_main(100, 1, 32'h0, 32'h00000013, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_main(101, 0, P, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_main(102, 0, P, 0, 0, 0, 1);

    // ENABLE_C=0: compressed encodings are treated as 32-bit
    @(negedge clk);
    iv2 = 1; id2 = 32'h45054501;
    @(negedge clk);
    iv2 = 0; rdy2 = 1;
    #1;
    chk("noc_valid", 200, {31'b0, ov2}, 32'd1);
    chk("noc_pc", 200, opc2, P);
    chk("noc_instr", 200, oi2, 32'h45054501);
    chk("noc_compressed", 200, {31'b0, oc2}, 32'd0);
    @(negedge clk);
    rdy2 = 0; fl2 = 1; rpc2 = 32'h20000006;
    #1;
    chk("noc_valid", 201, {31'b0, ov2}, 32'd0);
    chk("noc_pc", 201, opc2, P + 4);
    @(negedge clk);
    fl2 = 0; iv2 = 1; id2 = 32'hABCD0001;
    @(negedge clk);
    iv2 = 0;
    #1;
    chk("noc_valid", 202, {31'b0, ov2}, 32'd1);
    chk("noc_pc", 202, opc2, 32'h20000006);
    chk("noc_instr", 202, oi2, 32'hABCD0001);
    chk("noc_compressed", 202, {31'b0, oc2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
